// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline forwarding/hazard logic.
//   FWD_RF   - operand comes from the register file
//   FWD_EALU - operand comes from the ALU result sitting in EXE
//   FWD_MALU - operand comes from the ALU result sitting in MEM
//   FWD_MMEM - operand comes from the load data returned in MEM
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF   = 2'b00;
    localparam logic [FWD_W-1:0] FWD_EALU = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MALU = 2'b10;
    localparam logic [FWD_W-1:0] FWD_MMEM = 2'b11;

endpackage : pipe_pkg

// File: rtl/fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Forwarding select for one ID-stage source operand. Compares the operand
// specifier against the EXE and MEM shadow slots and picks the youngest
// producer. Also flags a load in EXE that this operand depends on, which the
// parent turns into a load-use stall.
//
// Ports
//   id_src    in   NREG  source specifier read by the ID instruction
//   ewreg     in   1     EXE slot writes a register
//   em2reg    in   1     EXE slot is a load
//   edest     in   NREG  EXE slot destination
//   mwreg     in   1     MEM slot writes a register
//   mm2reg    in   1     MEM slot is a load
//   mdest     in   NREG  MEM slot destination
//   fwd       out  2     forwarding select (pipe_pkg encoding)
//   load_hit  out  1     EXE slot is a load producing id_src
// -----------------------------------------------------------------------------
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int NREG = 5
) (
    input  logic [NREG-1:0]  id_src,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [NREG-1:0]  edest,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [NREG-1:0]  mdest,
    output logic [FWD_W-1:0] fwd,
    output logic             load_hit
);

    logic src_nz;
    logic e_match;
    logic m_match;

    // Register 0 is hard-wired to zero, so a write to it is never a producer.
    assign src_nz  = (id_src != '0);
    assign e_match = src_nz & ewreg & (edest == id_src);
    assign m_match = src_nz & mwreg & (mdest == id_src);

    assign load_hit = e_match & em2reg;

    // NOTE: fwd gets a default before any branch so the block is purely
    // combinational; a path that leaves it unassigned would infer a latch.
    always_comb begin
        fwd = FWD_RF;
        // A load in EXE has no data yet, so it falls through to MEM; the
        // resulting hazard is handled by the stall instead.
        if (e_match & ~em2reg) begin
            fwd = FWD_EALU;
        end else if (m_match & mm2reg) begin
            fwd = FWD_MMEM;
        end else if (m_match) begin
            fwd = FWD_MALU;
        end
    end

endmodule : fwd_sel

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and load-use hazard unit for a classic 5-stage pipeline. Keeps
// shadow copies of the register-write information of the instructions in EXE
// and MEM, produces the operand forwarding selects for the ID instruction, and
// stalls PC/IF-ID for one cycle when the ID instruction needs a load that is
// still in EXE. A taken branch in EXE flushes the ID instruction instead.
//
// Ports
//   clk             in   1     clock, rising edge
//   rst_n           in   1     asynchronous active-low reset
//   id_rs, id_rt    in   NREG  ID source specifiers
//   id_use_rs/rt    in   1     ID instruction actually reads rs / rt
//   id_wreg         in   1     ID instruction writes a register
//   id_m2reg        in   1     ID instruction is a load
//   id_dest         in   NREG  ID destination (after the regrt mux)
//   e_branch_taken  in   1     branch resolved taken in EXE
//   id_fwda/fwdb    out  2     forwarding selects for operand A / B
//   stall           out  1     hold PC and IF/ID, bubble into EXE
//   pc_wren         out  1     PC write enable (~stall)
//   ifid_wren       out  1     IF/ID write enable (~stall)
//   stall_cnt       out  CNTW  saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int NREG = 5,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREG-1:0]  id_rs,
    input  logic [NREG-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [NREG-1:0]  id_dest,
    input  logic             e_branch_taken,
    output logic [FWD_W-1:0] id_fwda,
    output logic [FWD_W-1:0] id_fwdb,
    output logic             stall,
    output logic             pc_wren,
    output logic             ifid_wren,
    output logic [CNTW-1:0]  stall_cnt
);

    // Shadow slots: the only pipeline state this unit owns.
    logic            ewreg, em2reg;
    logic [NREG-1:0] edest;
    logic            mwreg, mm2reg;
    logic [NREG-1:0] mdest;

    logic            load_hit_a;
    logic            load_hit_b;
    logic            load_use;
    logic            ex_load_en;

    fwd_sel #(.NREG(NREG)) u_sel_a (
        .id_src   (id_rs),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .edest    (edest),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mdest    (mdest),
        .fwd      (id_fwda),
        .load_hit (load_hit_a)
    );

    fwd_sel #(.NREG(NREG)) u_sel_b (
        .id_src   (id_rt),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .edest    (edest),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mdest    (mdest),
        .fwd      (id_fwdb),
        .load_hit (load_hit_b)
    );

    // Only operands the instruction really reads can create a hazard; the
    // selects for unused operands are still produced but ignored downstream.
    assign load_use = (id_use_rs & load_hit_a) | (id_use_rt & load_hit_b);

    // A taken branch flushes the ID instruction, so waiting for its operand
    // would be pointless: the flush wins over the stall.
    assign stall     = load_use & ~e_branch_taken;
    assign pc_wren   = ~stall;
    assign ifid_wren = ~stall;

    assign ex_load_en = ~stall & ~e_branch_taken;

    // NOTE: sequential state uses non-blocking assignments so the MEM slot
    // samples the EXE slot's old value on the same edge that EXE is reloaded.
    // The async reset clears the slots directly, which lets stall fall
    // combinationally while rst_n is still low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
            edest  <= '0;
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mdest  <= '0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mdest  <= edest;
            if (ex_load_en) begin
                ewreg  <= id_wreg;
                em2reg <= id_m2reg;
                edest  <= id_dest;
            end else begin
                ewreg  <= 1'b0;
                em2reg <= 1'b0;
                edest  <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule : fwd_hazard_unit
